// File: rtl/mby_msh_col_wr_arb.sv
// Credit-based round-robin arbiter: NUM_REQ local writers share one mesh column write port; MBY_MSH_COL_WR_ARB_PERF_CNT_EN adds per-requester grant counters.
// Latency: a handshake at edge N presents the write on o_wr_* in cycle N+1.
// Backpressure: o_req_rdy stays low while the registered credit count is zero or i_reset is high.
module mby_msh_col_wr_arb #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 64,
   parameter int CREDITS = 8,
   parameter int CNT_W   = 16
) (
   input  logic                          mclk,
   input  logic                          i_reset,
   input  logic [NUM_REQ-1:0]            i_req_vld,
   input  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]     i_req_data,
   output logic [NUM_REQ-1:0]            o_req_rdy,
   output logic                          o_wr_vld,
   output logic [ADDR_W-1:0]             o_wr_addr,
   output logic [DATA_W-1:0]             o_wr_data,
   output logic [$clog2(NUM_REQ)-1:0]    o_wr_src,
   input  logic                          i_crd_rtn,
   output logic [$clog2(CREDITS+1)-1:0]  o_crd_cnt,
`ifdef MBY_MSH_COL_WR_ARB_PERF_CNT_EN
   output logic [NUM_REQ*CNT_W-1:0]      o_grant_cnt,
`endif
   output logic                          o_crd_err
);

   localparam int SRC_W = $clog2(NUM_REQ);
   localparam int CRD_W = $clog2(CREDITS+1);
   localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(CREDITS);
   localparam logic [SRC_W:0]   NREQ     = (SRC_W+1)'(NUM_REQ);
   localparam logic [SRC_W-1:0] LAST_REQ = SRC_W'(NUM_REQ-1);

   logic [SRC_W-1:0] ptr;
   logic [SRC_W-1:0] win;
   logic [SRC_W-1:0] ptr_nxt;
   logic             found;
   logic             grant;
   logic [CRD_W-1:0] crd;
   logic [CRD_W-1:0] crd_nxt;
   logic             crd_ovf;

   // Scan from ptr upward with wrap; the first valid requester wins.
   always_comb begin : winner_search
      logic [SRC_W:0]   sum;
      logic [SRC_W-1:0] cand;
      win   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (SRC_W+1)'(i);
         if (sum >= NREQ) begin
            sum = sum - NREQ;
         end
         cand = sum[SRC_W-1:0];
         if (!found && i_req_vld[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign grant   = found && (crd != '0) && !i_reset;
   assign ptr_nxt = (win == LAST_REQ) ? '0 : win + SRC_W'(1);

   always_comb begin
      o_req_rdy = '0;
      if (grant) begin
         o_req_rdy[win] = 1'b1;
      end
   end

   // A return with the pool already full and nothing consumed is an overflow.
   always_comb begin
      crd_nxt = crd;
      crd_ovf = 1'b0;
      case ({grant, i_crd_rtn})
         2'b10: crd_nxt = crd - CRD_W'(1);
         2'b01: begin
            if (crd == CRD_MAX) begin
               crd_ovf = 1'b1;
            end else begin
               crd_nxt = crd + CRD_W'(1);
            end
         end
         default: crd_nxt = crd;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (i_reset) begin
         crd       <= CRD_MAX;
         ptr       <= '0;
         o_wr_vld  <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_wr_src  <= '0;
         o_crd_err <= 1'b0;
      end else begin
         crd      <= crd_nxt;
         o_wr_vld <= grant;
         if (crd_ovf) begin
            o_crd_err <= 1'b1;
         end
         if (grant) begin
            ptr       <= ptr_nxt;
            o_wr_addr <= i_req_addr[win*ADDR_W +: ADDR_W];
            o_wr_data <= i_req_data[win*DATA_W +: DATA_W];
            o_wr_src  <= win;
         end
      end
   end

   assign o_crd_cnt = crd;

`ifdef MBY_MSH_COL_WR_ARB_PERF_CNT_EN
   always_ff @(posedge mclk) begin
      if (i_reset) begin
         o_grant_cnt <= '0;
      end else if (grant) begin
         o_grant_cnt[win*CNT_W +: CNT_W] <= o_grant_cnt[win*CNT_W +: CNT_W] + CNT_W'(1);
      end
   end
`else
   // Grant statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_mby_msh_col_wr_arb.sv
// Bench for mby_msh_col_wr_arb: directed steps from the test plan, then a randomized phase against a reference model.
// Inputs change on the falling edge; o_req_rdy is sampled 1-2 ns later, registered outputs on the next falling edge.
module tb_mby_msh_col_wr_arb;

   localparam int N  = 4;
   localparam int AW = 20;
   localparam int DW = 64;
   localparam int CR = 8;
   localparam int CW = 16;

   logic            mclk = 1'b0;
   logic            rst;
   logic [N-1:0]    vld;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] data;
   logic            rtn;
   logic [N-1:0]    rdy;
   logic            wr_vld;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [1:0]      wr_src;
   logic [3:0]      crd_cnt;
   logic            crd_err;
`ifdef MBY_MSH_COL_WR_ARB_PERF_CNT_EN
   logic [N*CW-1:0] grant_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int            m_crd;
   int            m_ptr;
   int            m_src;
   int            last_g;
   bit            m_vld;
   bit            m_err;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   int            m_cnt[N];

   mby_msh_col_wr_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CREDITS(CR), .CNT_W(CW)) dut (
      .mclk       (mclk),
      .i_reset    (rst),
      .i_req_vld  (vld),
      .i_req_addr (addr),
      .i_req_data (data),
      .o_req_rdy  (rdy),
      .o_wr_vld   (wr_vld),
      .o_wr_addr  (wr_addr),
      .o_wr_data  (wr_data),
      .o_wr_src   (wr_src),
      .i_crd_rtn  (rtn),
      .o_crd_cnt  (crd_cnt),
`ifdef MBY_MSH_COL_WR_ARB_PERF_CNT_EN
      .o_grant_cnt(grant_cnt),
`endif
      .o_crd_err  (crd_err)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [63:0] onehot(input int g);
      logic [63:0] one;
      one = 64'd1;
      return (g < 0) ? 64'd0 : (one << g);
   endfunction

   task automatic new_req(input int r);
      if (r >= 0) begin
         addr[r*AW +: AW] = AW'($urandom);
         data[r*DW +: DW] = {$urandom, $urandom};
      end
   endtask

   task automatic model_reset();
      m_crd = CR; m_ptr = 0; m_src = 0; m_vld = 0; m_err = 0;
      m_addr = '0; m_data = '0;
      for (int r = 0; r < N; r++) m_cnt[r] = 0;
   endtask

   // One clock: check the grant, advance the model at the edge, check the registered outputs.
   task automatic cycle();
      int g;
      #1;
      g = (!rst && m_crd > 0) ? pick(vld, m_ptr) : -1;
      chk("rdy", 64'(rdy), onehot(g));
      @(posedge mclk);
      if (rst) begin
         model_reset();
      end else begin
         m_vld = (g >= 0);
         if (g >= 0) begin
            m_addr   = addr[g*AW +: AW];
            m_data   = data[g*DW +: DW];
            m_src    = g;
            m_ptr    = (g + 1) % N;
            m_cnt[g] = (m_cnt[g] + 1) % (1 << CW);
         end
         m_crd = m_crd - ((g >= 0) ? 1 : 0) + (rtn ? 1 : 0);
         if (m_crd > CR) begin
            m_crd = CR;
            m_err = 1;
         end
      end
      last_g = g;
      @(negedge mclk);
      chk("wr_vld", 64'(wr_vld), 64'(m_vld));
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", wr_data, m_data);
      chk("wr_src", 64'(wr_src), 64'(m_src));
      chk("crd_cnt", 64'(crd_cnt), 64'(m_crd));
      chk("crd_err", 64'(crd_err), 64'(m_err));
`ifdef MBY_MSH_COL_WR_ARB_PERF_CNT_EN
      for (int r = 0; r < N; r++) chk("grant_cnt", 64'(grant_cnt[r*CW +: CW]), 64'(m_cnt[r]));
`endif
   endtask

   task automatic pre_rdy(input string tag, input logic [63:0] exp);
      #1;
      chk(tag, 64'(rdy), exp);
   endtask

   initial begin
      vld = '0; addr = '0; data = '0; rtn = 0; rst = 1; last_g = -1;
      model_reset();
      @(negedge mclk);

      // Reset then idle
      cycle(); cycle();
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("idle_crd", 64'(crd_cnt), 64'd8);
         chk("idle_vld", 64'(wr_vld), 64'd0);
         chk("idle_err", 64'(crd_err), 64'd0);
      end

      // Full contention, credits returned every cycle
      vld = 4'hF; rtn = 1;
      for (int r = 0; r < N; r++) new_req(r);
      for (int i = 0; i < 12; i++) begin
         pre_rdy("rr_rdy", onehot(i % N));
         cycle();
         chk("rr_src", 64'(wr_src), 64'(i % N));
         chk("rr_crd", 64'(crd_cnt), 64'd8);
         new_req(last_g);
      end

      // Requester 2 alone drains the credit pool
      vld = 4'b0100; rtn = 0; new_req(2);
      for (int i = 0; i < CR; i++) begin
         pre_rdy("drain_rdy", 64'd4);
         cycle();
         new_req(2);
      end
      chk("drained_crd", 64'(crd_cnt), 64'd0);
      for (int i = 0; i < 3; i++) begin
         pre_rdy("starved_rdy", 64'd0);
         cycle();
      end
      rtn = 1;
      pre_rdy("rtn_not_same_cycle", 64'd0);
      cycle();
      rtn = 0;
      chk("rtn_wr_vld0", 64'(wr_vld), 64'd0);
      pre_rdy("rtn_grant", 64'd4);
      cycle();
      chk("rtn_wr_vld1", 64'(wr_vld), 64'd1);
      chk("rtn_crd", 64'(crd_cnt), 64'd0);
      vld = '0;
      cycle();
      chk("rtn_wr_vld_drop", 64'(wr_vld), 64'd0);

      // Grant and return together at crd=1, then overflow at full pool
      rtn = 1;
      cycle();
      chk("crd_one", 64'(crd_cnt), 64'd1);
      vld = 4'b0100; new_req(2);
      pre_rdy("both_rdy", 64'd4);
      cycle();
      chk("both_crd", 64'(crd_cnt), 64'd1);
      rtn = 0; new_req(2);
      pre_rdy("next_rdy", 64'd4);
      cycle();
      chk("next_crd", 64'(crd_cnt), 64'd0);
      vld = '0; rtn = 1;
      repeat (CR) cycle();
      chk("refill_crd", 64'(crd_cnt), 64'd8);
      chk("refill_err", 64'(crd_err), 64'd0);
      cycle();
      chk("ovf_err", 64'(crd_err), 64'd1);
      chk("ovf_crd", 64'(crd_cnt), 64'd8);
      rtn = 0;
      cycle();
      chk("err_sticky", 64'(crd_err), 64'd1);

      // Reset mid-burst with 3 credits outstanding
      vld = 4'b0110; new_req(1); new_req(2);
      for (int i = 0; i < 3; i++) begin
         cycle();
         new_req(last_g);
      end
      chk("burst_crd", 64'(crd_cnt), 64'd5);
      rst = 1;
      pre_rdy("rst_rdy", 64'd0);
      cycle();
      chk("rst_wr_vld", 64'(wr_vld), 64'd0);
      chk("rst_crd", 64'(crd_cnt), 64'd8);
      chk("rst_err", 64'(crd_err), 64'd0);
      rst = 0; vld = 4'hF; new_req(0); new_req(3);
      pre_rdy("rst_ptr_rdy", 64'd1);
      cycle();
      chk("rst_ptr_src", 64'(wr_src), 64'd0);
      new_req(last_g);

      // Randomized traffic; requests hold until granted
      for (int i = 0; i < 400; i++) begin
         cycle();
         if (rst) begin
            rst = 0;
         end else begin
            rst = ($urandom_range(0, 49) == 0);
         end
         for (int r = 0; r < N; r++) begin
            if (vld[r] && last_g == r) begin
               vld[r] = 1'($urandom_range(0, 1));
               new_req(r);
            end else if (!vld[r]) begin
               vld[r] = ($urandom_range(0, 2) == 0);
               new_req(r);
            end
         end
         rtn = ($urandom_range(0, 1) == 1) && (m_crd < CR || $urandom_range(0, 7) == 0);
      end
      rst = 0; rtn = 0;

`ifdef MBY_MSH_COL_WR_ARB_PERF_CNT_EN
      // Even split of 100 contended grants
      rst = 1;
      cycle();
      rst = 0; vld = 4'hF; rtn = 1;
      for (int r = 0; r < N; r++) new_req(r);
      repeat (100) begin
         cycle();
         new_req(last_g);
      end
      for (int r = 0; r < N; r++) chk("perf_25", 64'(grant_cnt[r*CW +: CW]), 64'd25);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mby_msh_col_wr_arb.md
# mby_msh_col_wr_arb

Credit-based round-robin arbiter that shares one mesh column write interface among NUM_REQ local write requesters at a mesh boundary (e.g. the north or south edge feeding the `mby_msh_col_wr_if` ports of `mby_msh`). It grants at most one request per cycle and registers the winning write onto the column. It tracks downstream buffer credits so that it never issues a write the mesh cannot accept.

## Interface
- NUM_REQ, 4: number of requesters (2..16).
- ADDR_W, 20: write address width.
- DATA_W, 64: write data width.
- CREDITS, 8: downstream buffer depth; initial credit count (1..255).
- CNT_W, 16: width of per-requester grant counters (perf feature only).
- mclk  in  1  mesh clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_vld  in  NUM_REQ  per-requester request valid.
- i_req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester r at [r*ADDR_W +: ADDR_W].
- i_req_data  in  NUM_REQ*DATA_W  packed data; same packing.
- o_req_rdy  out  NUM_REQ  one-hot grant (combinational); transfer when vld&rdy.
- o_wr_vld  out  1  registered column write valid.
- o_wr_addr  out  ADDR_W  registered write address.
- o_wr_data  out  DATA_W  registered write data.
- o_wr_src  out  $clog2(NUM_REQ)  index of the requester that sourced the current write.
- i_crd_rtn  in  1  one credit returned per asserted cycle.
- o_crd_cnt  out  $clog2(CREDITS+1)  current credit count.
- o_crd_err  out  1  sticky credit-overflow error.
- o_grant_cnt  out  NUM_REQ*CNT_W  per-requester grant counters (present only with the macro).

## Operation
- State: credit counter `crd`, round-robin pointer `ptr` (0..NUM_REQ-1), output register, sticky error flag.
- Grant eligibility: `crd != 0` (registered value only; a same-cycle i_crd_rtn does not enable a grant) and i_reset low.
- Winner: first r with i_req_vld[r]=1, searched from `ptr` upward with wrap. o_req_rdy = onehot(winner), else 0. o_req_rdy never depends on i_req_addr or i_req_data.
- On grant: `ptr <= winner+1` (mod NUM_REQ). Output register loads the winner's addr and data, `o_wr_src <= winner`, `o_wr_vld <= 1`. With no grant: `o_wr_vld <= 0`; addr, data and src hold.
- Credit update: `crd <= crd - grant + i_crd_rtn`. Simultaneous grant and return leaves `crd` unchanged.
- Overflow: i_crd_rtn with `crd == CREDITS` and no grant saturates `crd` at CREDITS and sets o_crd_err. o_crd_err clears only on reset.
- Requester rule: once asserted, i_req_vld[r] and its addr/data hold until granted. The arbiter does not check this; the bench asserts it.
- Reset values: crd=CREDITS, ptr=0, o_wr_vld=0, o_wr_addr=0, o_wr_data=0, o_wr_src=0, o_crd_err=0, o_grant_cnt=0.
- o_req_rdy=0 while i_reset=1.
- Reset mid-operation: in-flight o_wr_vld drops on the next edge. Credits restore to CREDITS, because the mesh is reset together with the arbiter.

## Timing
- Grant-to-write latency: 1 cycle. A handshake at edge N gives o_wr_vld high in cycle N+1.
- Throughput: one write per cycle while credits are available. Back-to-back grants to different requesters are permitted.
- Credit return at cycle N becomes grantable at cycle N+1.
- With CREDITS outstanding and no returns, o_req_rdy stays 0 indefinitely.
- Fairness: any continuously requesting requester is granted within NUM_REQ consecutive grants.

## Configuration
- MBY_MSH_COL_WR_ARB_PERF_CNT_EN:
  - Defined: o_grant_cnt exists. Counter r increments on each grant to r, wraps modulo 2^CNT_W, and resets to 0.
  - Undefined: o_grant_cnt port and counters are absent. Arbitration behaviour is identical either way.

## Test plan
- Reset then idle: o_crd_cnt=8, o_wr_vld=0, o_req_rdy=0, o_crd_err=0 for 10 cycles.
- All 4 requesters valid continuously, i_crd_rtn tied high: grants 0,1,2,3,0,… one per cycle; o_wr_src follows the same sequence one cycle later; o_crd_cnt stays 8.
- Requester 2 only, no returns: 8 writes on consecutive cycles, then o_req_rdy=0 and o_crd_cnt=0. One i_crd_rtn pulse gives exactly one more write, two cycles later at o_wr_vld.
- Grant and i_crd_rtn in the same cycle at crd=1: crd stays 1 and the next-cycle grant proceeds. i_crd_rtn at crd=8 with no grant: o_crd_err=1, crd stays 8.
- i_reset asserted mid-burst with 3 credits outstanding: next cycle o_wr_vld=0, o_crd_cnt=8, ptr=0 (requester 0 wins first after release).
- With the macro defined: 100 fully contended cycles across 4 requesters give o_grant_cnt=25 each. With it undefined, the bench compiles without the port.
